// File: rtl/reg_arbiter_if.sv
// Requester/output bundle for reg_arbiter; the lock lane exists only when ARB_LOCK_EN is defined.
interface reg_arbiter_if #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 4
);
  localparam int unsigned W = $clog2(R);

  logic [R-1:0]   req;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   gnt;
  logic [N-1:0]   q;
  logic           q_valid;
  logic           q_ready;
  logic [W-1:0]   owner;
`ifdef ARB_LOCK_EN
  logic [R-1:0]   lock;

  modport master (output req, req_data, q_ready, lock, input gnt, q, q_valid, owner);
  modport slave  (input req, req_data, q_ready, lock, output gnt, q, q_valid, owner);
`else
  modport master (output req, req_data, q_ready, input gnt, q, q_valid, owner);
  modport slave  (input req, req_data, q_ready, output gnt, q, q_valid, owner);
`endif
endinterface

// File: rtl/reg_arbiter.sv
// Round-robin arbiter feeding one shared output register with a valid/ready drain.
// Optional ownership lock enabled by defining ARB_LOCK_EN.
module reg_arbiter #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_arbiter_if.slave bus
);
  localparam int unsigned W = $clog2(R);

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] FULL   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] ptr;
  logic [N-1:0] q;
  logic         q_valid;
  logic [W-1:0] owner;

  logic         free;
  logic         xfer;
  logic         qv_next;
  logic         found;
  logic [R-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic [W-1:0] sel;
  logic [W-1:0] ptr_next;

  assign free = !q_valid || bus.q_ready;

  // Grant is masked during reset so a pending request is never captured.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    if (rst_n && free) begin
      if (state == LOCKED) begin
        if (bus.req[owner]) begin
          gnt[owner] = 1'b1;
          gnt_idx    = owner;
        end
      end else begin
        for (int unsigned k = 0; k < R; k++) begin
          sel = W'((32'(ptr) + k) % R);
          if (!found && bus.req[sel]) begin
            found    = 1'b1;
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
          end
        end
      end
    end
  end

  assign xfer     = |gnt;
  assign qv_next  = xfer || (q_valid && !bus.q_ready);
  assign ptr_next = (gnt_idx == W'(R - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
      state   <= EMPTY;
    end else begin
      q_valid <= qv_next;
      if (xfer) begin
        q     <= bus.req_data[gnt_idx*N +: N];
        owner <= gnt_idx;
      end
`ifdef ARB_LOCK_EN
      // Locked transfers hold PTR; a vanished owner request releases the lock.
      if (xfer && bus.lock[gnt_idx]) begin
        state <= LOCKED;
      end else begin
        if (xfer)
          ptr <= ptr_next;
        if (state != LOCKED || xfer || !bus.req[owner])
          state <= qv_next ? FULL : EMPTY;
      end
`else
      if (xfer)
        ptr <= ptr_next;
      state <= qv_next ? FULL : EMPTY;
`endif
    end
  end

  assign bus.gnt     = gnt;
  assign bus.q       = q;
  assign bus.q_valid = q_valid;
  assign bus.owner   = owner;
endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: vector table, corner sequences and a randomized model comparison.
module tb_reg_arbiter;
  localparam int unsigned N = 16;
  localparam int unsigned R = 4;
  localparam int unsigned W = $clog2(R);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_arbiter_if #(.N(N), .R(R)) bus ();
  reg_arbiter #(.N(N), .R(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [R-1:0]   req;
    logic [R*N-1:0] data;
    logic           rdy;
    logic [R-1:0]   gnt;
    logic [N-1:0]   q;
    logic           qv;
    logic [W-1:0]   own;
  } vec_t;

  vec_t tbl[15];

  localparam logic [R*N-1:0] D1 = {16'h000B, 16'h1234, 16'h0009, 16'h0008};
  localparam logic [R*N-1:0] D2 = {16'h000B, 16'h000A, 16'h0009, 16'h0008};

  // Reference model state: pointer, valid flag and register contents.
  int           m_ptr;
  bit           m_qv;
  logic [N-1:0] m_q;
  int           m_own;

  function automatic int model_pick(input int p, input bit qv, input bit rdy, input logic [R-1:0] rq);
    if (qv && !rdy) return -1;
    for (int k = 0; k < int'(R); k++) begin
      if (rq[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.q_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [R-1:0]   rq;
    logic [R*N-1:0] rdat;
    logic           rrdy;
    logic [R-1:0]   exp_g;
    logic [N-1:0]   rr_q;
    int             pick;

    bus.req = '0;
    bus.req_data = '0;
    bus.q_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif

    tbl[0]  = '{req:4'b0100, data:D1, rdy:1'b0, gnt:4'b0100, q:16'h1234, qv:1'b1, own:2'd2};
    tbl[1]  = '{req:4'b0100, data:D1, rdy:1'b0, gnt:4'b0000, q:16'h1234, qv:1'b1, own:2'd2};
    tbl[2]  = '{req:4'b0000, data:D2, rdy:1'b1, gnt:4'b0000, q:16'h1234, qv:1'b0, own:2'd2};
    tbl[3]  = '{req:4'b0000, data:D2, rdy:1'b1, gnt:4'b0000, q:16'h1234, qv:1'b0, own:2'd2};
    tbl[4]  = '{req:4'b1111, data:D2, rdy:1'b1, gnt:4'b1000, q:16'h000B, qv:1'b1, own:2'd3};
    tbl[5]  = '{req:4'b1111, data:D2, rdy:1'b1, gnt:4'b0001, q:16'h0008, qv:1'b1, own:2'd0};
    tbl[6]  = '{req:4'b1111, data:D2, rdy:1'b1, gnt:4'b0010, q:16'h0009, qv:1'b1, own:2'd1};
    tbl[7]  = '{req:4'b1111, data:D2, rdy:1'b1, gnt:4'b0100, q:16'h000A, qv:1'b1, own:2'd2};
    tbl[8]  = '{req:4'b1111, data:D2, rdy:1'b1, gnt:4'b1000, q:16'h000B, qv:1'b1, own:2'd3};
    tbl[9]  = '{req:4'b0011, data:D2, rdy:1'b1, gnt:4'b0001, q:16'h0008, qv:1'b1, own:2'd0};
    tbl[10] = '{req:4'b0011, data:D2, rdy:1'b0, gnt:4'b0000, q:16'h0008, qv:1'b1, own:2'd0};
    tbl[11] = '{req:4'b0011, data:D2, rdy:1'b0, gnt:4'b0000, q:16'h0008, qv:1'b1, own:2'd0};
    tbl[12] = '{req:4'b0011, data:D2, rdy:1'b0, gnt:4'b0000, q:16'h0008, qv:1'b1, own:2'd0};
    tbl[13] = '{req:4'b0011, data:D2, rdy:1'b1, gnt:4'b0010, q:16'h0009, qv:1'b1, own:2'd1};
    tbl[14] = '{req:4'b0000, data:D2, rdy:1'b1, gnt:4'b0000, q:16'h0009, qv:1'b0, own:2'd1};

    // Reset state
    #2;
    chk("reset_q", 64'(bus.q), 64'h0);
    chk("reset_qv", 64'(bus.q_valid), 64'h0);
    chk("reset_owner", 64'(bus.owner), 64'h0);
    chk("reset_gnt", 64'(bus.gnt), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      bus.req = tbl[i].req;
      bus.req_data = tbl[i].data;
      bus.q_ready = tbl[i].rdy;
      #1 chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_q", i), 64'(bus.q), 64'(tbl[i].q));
      chk($sformatf("tbl%0d_qv", i), 64'(bus.q_valid), 64'(tbl[i].qv));
      chk($sformatf("tbl%0d_owner", i), 64'(bus.owner), 64'(tbl[i].own));
    end

    // Mid-stream asynchronous reset with a word held and a grant pending
    bus.req = 4'b1111;
    bus.req_data = D2;
    bus.q_ready = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_qv", 64'(bus.q_valid), 64'h1);
    bus.q_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 64'(bus.q), 64'h0);
    chk("arst_qv", 64'(bus.q_valid), 64'h0);
    chk("arst_owner", 64'(bus.owner), 64'h0);
    chk("arst_gnt", 64'(bus.gnt), 64'h0);
    @(posedge clk);
    #1;
    chk("arst_nocap_q", 64'(bus.q), 64'h0);
    chk("arst_nocap_qv", 64'(bus.q_valid), 64'h0);
    rst_n = 1'b1;

    // Fairness after reset: 0,1,2,3,0 one per cycle
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      rr_q = 16'h0008 + 16'(i % R);
      chk($sformatf("rr%0d_q", i), 64'(bus.q), 64'(rr_q));
      chk($sformatf("rr%0d_qv", i), 64'(bus.q_valid), 64'h1);
    end

`ifdef ARB_LOCK_EN
    // Lock: owner 0 keeps the register for three locked transfers plus one release transfer
    do_reset();
    bus.req = 4'b0011;
    bus.req_data = D2;
    bus.q_ready = 1'b1;
    bus.lock = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.lock = 4'b0000;
      #1 chk($sformatf("lock%0d_gnt", i), 64'(bus.gnt), (i < 4) ? 64'h1 : 64'h2);
      @(posedge clk);
      #1 chk($sformatf("lock%0d_owner", i), 64'(bus.owner), (i < 4) ? 64'h0 : 64'h1);
    end
`endif

    // Randomized comparison against the reference model
    do_reset();
    m_ptr = 0;
    m_qv = 1'b0;
    m_q = '0;
    m_own = 0;
    for (int c = 0; c < 1500; c++) begin
      rq = R'($urandom_range(0, (1 << R) - 1));
      rdat = {$urandom, $urandom};
      rrdy = ($urandom_range(0, 3) != 0);
      bus.req = rq;
      bus.req_data = rdat;
      bus.q_ready = rrdy;
      pick = model_pick(m_ptr, m_qv, rrdy, rq);
      exp_g = '0;
      if (pick >= 0) exp_g[pick] = 1'b1;
      #1 chk("rnd_gnt", 64'(bus.gnt), 64'(exp_g));
      if (pick >= 0) begin
        m_q = rdat[pick*N +: N];
        m_own = pick;
        m_qv = 1'b1;
        m_ptr = (pick + 1) % R;
      end else if (m_qv && rrdy) begin
        m_qv = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rnd_q", 64'(bus.q), 64'(m_q));
      chk("rnd_qv", 64'(bus.q_valid), 64'(m_qv));
      chk("rnd_owner", 64'(bus.owner), 64'(m_own));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
